// File: rtl/mult_pipe_hs.sv
// mult_pipe_hs: pipelined SIZE x SIZE multiplier with a valid/ready handshake.
// Each operation carries its own signed/unsigned mode (tc).
// The pipeline has one operand register followed by LVL product stages.
// A single global stall freezes every stage while the output is blocked.
// Optional sideband tag: define MULT_PIPE_TAG_EN to build tag_in/tag_out.
// Each tag travels with its operation.
module mult_pipe_hs #(
    parameter int SIZE  = 16,
    parameter int LVL   = 2,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    input  logic                tc,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [2*SIZE-1:0]   pdt
`ifdef MULT_PIPE_TAG_EN
    ,
    input  logic [TAG_W-1:0]    tag_in,
    output logic [TAG_W-1:0]    tag_out
`endif
);

    localparam int PW = 2 * SIZE;

    logic            stall;
    logic            op_vld_reg;
    logic [SIZE-1:0] a_reg;
    logic [SIZE-1:0] b_reg;
    logic            tc_reg;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   prod;
`ifdef MULT_PIPE_TAG_EN
    logic [TAG_W-1:0] op_tag_reg;
`endif

    // The only thing that can block the pipe is an unconsumed result at the output.
    assign stall  = out_vld & ~out_rdy;
    assign in_rdy = ~stall;

    // Operand register: a bubble enters when nothing is offered.
    // Data is only loaded with a valid operation, so it never changes on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            tc_reg     <= 1'b0;
`ifdef MULT_PIPE_TAG_EN
            op_tag_reg <= '0;
`endif
        end else if (!stall) begin
            op_vld_reg <= in_vld;
            if (in_vld) begin
                a_reg  <= a;
                b_reg  <= b;
                tc_reg <= tc;
`ifdef MULT_PIPE_TAG_EN
                op_tag_reg <= tag_in;
`endif
            end
        end
    end

    // Extend both operands to the full product width, by sign or by zero.
    // The low PW bits of their product are then exact in either mode.
    always_comb begin
        a_ext = tc_reg ? {{SIZE{a_reg[SIZE-1]}}, a_reg} : {{SIZE{1'b0}}, a_reg};
        b_ext = tc_reg ? {{SIZE{b_reg[SIZE-1]}}, b_reg} : {{SIZE{1'b0}}, b_reg};
        prod  = a_ext * b_ext;
    end

    // Stage 0 captures the product and later stages only delay it.
    // The product is held so that pdt keeps its last value across bubbles.
    for (genvar gi = 0; gi < LVL; gi++) begin : g_stg
        logic          vld_r;
        logic [PW-1:0] pdt_r;
        logic          vld_src;
        logic [PW-1:0] pdt_src;
`ifdef MULT_PIPE_TAG_EN
        logic [TAG_W-1:0] tag_r;
        logic [TAG_W-1:0] tag_src;
`endif

        if (gi == 0) begin : g_src
            assign vld_src = op_vld_reg;
            assign pdt_src = prod;
`ifdef MULT_PIPE_TAG_EN
            assign tag_src = op_tag_reg;
`endif
        end else begin : g_src
            assign vld_src = g_stg[gi-1].vld_r;
            assign pdt_src = g_stg[gi-1].pdt_r;
`ifdef MULT_PIPE_TAG_EN
            assign tag_src = g_stg[gi-1].tag_r;
`endif
        end

        // Advance with the rest of the pipe and hold while it is stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                pdt_r <= '0;
`ifdef MULT_PIPE_TAG_EN
                tag_r <= '0;
`endif
            end else if (!stall) begin
                vld_r <= vld_src;
                if (vld_src) begin
                    pdt_r <= pdt_src;
`ifdef MULT_PIPE_TAG_EN
                    tag_r <= tag_src;
`endif
                end
            end
        end
    end

    // The outputs are taken straight from the last stage's registers.
    assign out_vld = g_stg[LVL-1].vld_r;
    assign pdt     = g_stg[LVL-1].pdt_r;
`ifdef MULT_PIPE_TAG_EN
    assign tag_out = g_stg[LVL-1].tag_r;
`endif

endmodule

// File: tb/tb_mult_pipe_hs.sv
// tb_mult_pipe_hs: directed self-checking bench for mult_pipe_hs (SIZE=16, LVL=2).
// Defining MULT_PIPE_TAG_EN also checks the sideband tag.
module tb_mult_pipe_hs;

    localparam int SIZE  = 16;
    localparam int LVL   = 2;
    localparam int TAG_W = 4;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] a;
    logic [15:0] b;
    logic        tc;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] pdt;
`ifdef MULT_PIPE_TAG_EN
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // Operand and result vectors, all worked out by hand.
    logic [15:0] va [10];
    logic [15:0] vb [10];
    logic        vt [10];
    logic [31:0] vp [10];

    mult_pipe_hs #(.SIZE(SIZE), .LVL(LVL), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .a       (a),
        .b       (b),
        .tc      (tc),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .pdt     (pdt)
`ifdef MULT_PIPE_TAG_EN
        ,
        .tag_in  (tag_in),
        .tag_out (tag_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Offer one operation and count the edges until its result shows up.
    task automatic single(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic tv, input logic [31:0] exp);
        int cnt;
        @(negedge clk);
        in_vld = 1'b1; a = av; b = bv; tc = tv;
        cnt = 0;
        while (cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) in_vld = 1'b0;
            #1;
            if (out_vld) break;
        end
        chk({name, "_lat"}, 64'(cnt), 64'(LVL + 1));
        chk({name, "_pdt"}, 64'(pdt), 64'(exp));
    endtask

    // Push n vectors through and check that each result comes out once, in order.
    // out_rdy is held low on cycles stall_lo..stall_hi.
    task automatic run_stream(input string name, input int n, input int stall_lo, input int stall_hi);
        logic [31:0] exp_q[$];
`ifdef MULT_PIPE_TAG_EN
        logic [TAG_W-1:0] tag_q[$];
`endif
        int idx = 0, rcv = 0, cyc = 0, first = -1, last = -1;
        while (rcv < n && cyc < 200) begin
            @(negedge clk);
            out_rdy = !(cyc >= stall_lo && cyc <= stall_hi);
            if (idx < n) begin
                in_vld = 1'b1; a = va[idx]; b = vb[idx]; tc = vt[idx];
`ifdef MULT_PIPE_TAG_EN
                tag_in = TAG_W'(idx + 1);
`endif
            end else begin
                in_vld = 1'b0;
            end
            #1;
            if (out_vld && !out_rdy) begin
                chk({name, "_stall_in_rdy"}, 64'(in_rdy), 64'd0);
                if (exp_q.size() == 0) chk({name, "_spurious"}, 64'd1, 64'd0);
                else chk({name, "_stall_pdt"}, 64'(pdt), 64'(exp_q[0]));
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk({name, "_spurious"}, 64'd1, 64'd0);
                end else begin
                    chk($sformatf("%s_pdt%0d", name, rcv), 64'(pdt), 64'(exp_q.pop_front()));
`ifdef MULT_PIPE_TAG_EN
                    chk($sformatf("%s_tag%0d", name, rcv), 64'(tag_out), 64'(tag_q.pop_front()));
`endif
                end
                rcv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back(vp[idx]);
`ifdef MULT_PIPE_TAG_EN
                tag_q.push_back(TAG_W'(idx + 1));
`endif
                idx++;
            end
            cyc++;
        end
        chk({name, "_count"}, 64'(rcv), 64'(n));
        if (stall_lo > stall_hi) chk({name, "_contig"}, 64'(last - first), 64'(n - 1));
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        // Nothing may be left over or repeated once the stream has drained.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk({name, "_drained"}, 64'(out_vld), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; a = '0; b = '0; tc = 1'b0; out_rdy = 1'b1;
`ifdef MULT_PIPE_TAG_EN
        tag_in = '0;
`endif
        // Each vector: a, b, tc and the product worked out by hand.
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vt[0] = 1'b0; vp[0] = 32'hFFFE0001;
        va[1] = 16'hFFFF; vb[1] = 16'h0003; vt[1] = 1'b1; vp[1] = 32'hFFFFFFFD;
        va[2] = 16'hFFFF; vb[2] = 16'h0003; vt[2] = 1'b0; vp[2] = 32'h0002FFFD;
        va[3] = 16'h8000; vb[3] = 16'h8000; vt[3] = 1'b1; vp[3] = 32'h40000000;
        va[4] = 16'h8000; vb[4] = 16'h7FFF; vt[4] = 1'b1; vp[4] = 32'hC0008000;
        va[5] = 16'h8000; vb[5] = 16'h7FFF; vt[5] = 1'b0; vp[5] = 32'h3FFF8000;
        va[6] = 16'h0000; vb[6] = 16'h1234; vt[6] = 1'b1; vp[6] = 32'h00000000;
        va[7] = 16'h0010; vb[7] = 16'h0010; vt[7] = 1'b0; vp[7] = 32'h00000100;
        va[8] = 16'hFFFE; vb[8] = 16'hFFFE; vt[8] = 1'b1; vp[8] = 32'h00000004;
        va[9] = 16'h1234; vb[9] = 16'h0100; vt[9] = 1'b0; vp[9] = 32'h00123400;

        #12;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_pdt", 64'(pdt), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
`ifdef MULT_PIPE_TAG_EN
        chk("rst_tag", 64'(tag_out), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        single("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        single("s_m1x3", 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD);
        single("u_m1x3", 16'hFFFF, 16'h0003, 1'b0, 32'h0002FFFD);
        single("s_minsq", 16'h8000, 16'h8000, 1'b1, 32'h40000000);

        run_stream("stream", 10, 1, 0);
        run_stream("bp", 8, 4, 8);
        run_stream("bp4", 4, 2, 3);

        // Reset with three operations in flight: outputs must clear at once.
        @(negedge clk);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; a = va[i]; b = vb[i]; tc = vt[i];
            @(negedge clk);
        end
        in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("amid_rst_out_vld", 64'(out_vld), 64'd0);
        chk("amid_rst_pdt", 64'(pdt), 64'd0);
        chk("amid_rst_in_rdy", 64'(in_rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_stale", 64'(out_vld), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
